dual_port_ram_arbiter: RTL and testbench

- Shares one synchronous dual-port RAM among REQUESTERS clients.
- Separate round-robin arbitration for the RAM write port and the RAM read port.
- Per cycle: at most one write and one read are granted.
- Read responses are routed back to the owning requester one cycle after grant.
- Sits between client blocks (DMA engines, CPUs, packet buffers) and a dual-port RAM instance driven from the same clock.

---
 rtl/dual_port_ram_arbiter_pkg.sv | 32 +++
 rtl/dual_port_ram_arbiter_round_robin_arbiter.sv | 60 ++++++
 rtl/dual_port_ram_arbiter.sv | 112 +++++++++++
 tb/tb_dual_port_ram_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_arbiter_pkg.sv
// Shared defaults and index helpers for the dual-port RAM arbiter.
// Used by the round-robin arbiters and by the top level.
package dual_port_ram_arbiter_pkg;

  localparam int DEFAULT_REQUESTERS = 4;
  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Next round-robin start position: one past the winner, wrapping at count.
  function automatic int next_index(input int current, input int count);
    int result;
    if (current + 1 >= count) begin
      result = 0;
    end else begin
      result = current + 1;
    end
    return result;
  endfunction

  // Requester index reached by stepping offset places from start, modulo count.
  function automatic int wrap_index(input int start, input int offset, input int count);
    int result;
    result = start + offset;
    if (result >= count) begin
      result = result - count;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/dual_port_ram_arbiter_round_robin_arbiter.sv
// Round-robin arbiter: the search starts at an internal pointer, and the pointer moves
// to one past each winner. Grants are combinational and held at zero during reset.
module round_robin_arbiter
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = DEFAULT_REQUESTERS,
  parameter int INDEX_WIDTH = $clog2(REQUESTERS)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [REQUESTERS-1:0]  request,
  output logic [REQUESTERS-1:0]  grant,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid
);

  logic [INDEX_WIDTH-1:0] pointer_r;
  logic [INDEX_WIDTH-1:0] candidate_s;

  // The search runs from the farthest offset back to the nearest, so the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    candidate_s = '0;
    if (resetn) begin
      for (int offset = REQUESTERS - 1; offset >= 0; offset--) begin
        candidate_s = INDEX_WIDTH'(wrap_index(int'(pointer_r), offset, REQUESTERS));
        if (request[candidate_s]) begin
          grant_index = candidate_s;
          grant_valid = 1'b1;
        end else begin
          grant_index = grant_index;
          grant_valid = grant_valid;
        end
      end
      if (grant_valid) begin
        grant[grant_index] = 1'b1;
      end else begin
        grant = '0;
      end
    end else begin
      grant       = '0;
      grant_index = '0;
      grant_valid = 1'b0;
    end
  end

  // The pointer advances past the winner and holds when there is no request.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pointer_r <= '0;
    end else if (grant_valid) begin
      pointer_r <= INDEX_WIDTH'(next_index(int'(grant_index), REQUESTERS));
    end else begin
      pointer_r <= pointer_r;
    end
  end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Shares one synchronous dual-port RAM among several clients. Write and read ports
// each use an independent round-robin arbiter, and read data returns to its owner one cycle later.
module dual_port_ram_arbiter
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int REQUESTERS    = DEFAULT_REQUESTERS,
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int INDEX_WIDTH   = $clog2(REQUESTERS)
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [REQUESTERS-1:0]             write_request_valid,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] write_request_address,
  input  logic [REQUESTERS*WIDTH-1:0]       write_request_data,
  output logic [REQUESTERS-1:0]             write_request_ready,
  input  logic [REQUESTERS-1:0]             read_request_valid,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] read_request_address,
  output logic [REQUESTERS-1:0]             read_request_ready,
  output logic [REQUESTERS-1:0]             read_response_valid,
  output logic [WIDTH-1:0]                  read_response_data,
  output logic                              ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0]          ram_write_address,
  output logic [WIDTH-1:0]                  ram_write_data,
  output logic                              ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0]          ram_read_address,
  input  logic [WIDTH-1:0]                  ram_read_data
);

  logic [INDEX_WIDTH-1:0] write_index_s;
  logic                   write_grant_valid_s;
  logic [INDEX_WIDTH-1:0] read_index_s;
  logic                   read_grant_valid_s;
  logic [INDEX_WIDTH-1:0] response_index_r;
  logic                   response_valid_r;

  round_robin_arbiter #(
    .REQUESTERS  (REQUESTERS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) write_arbiter (
    .clock       (clock),
    .resetn      (resetn),
    .request     (write_request_valid),
    .grant       (write_request_ready),
    .grant_index (write_index_s),
    .grant_valid (write_grant_valid_s)
  );

  round_robin_arbiter #(
    .REQUESTERS  (REQUESTERS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) read_arbiter (
    .clock       (clock),
    .resetn      (resetn),
    .request     (read_request_valid),
    .grant       (read_request_ready),
    .grant_index (read_index_s),
    .grant_valid (read_grant_valid_s)
  );

  // Route the write winner's address and data to the RAM write port.
  always_comb begin
    ram_write_enable  = write_grant_valid_s;
    ram_write_address = '0;
    ram_write_data    = '0;
    if (write_grant_valid_s) begin
      ram_write_address = write_request_address[int'(write_index_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      ram_write_data    = write_request_data[int'(write_index_s)*WIDTH +: WIDTH];
    end else begin
      ram_write_address = '0;
      ram_write_data    = '0;
    end
  end

  // Route the read winner's address to the RAM read port.
  always_comb begin
    ram_read_enable  = read_grant_valid_s;
    ram_read_address = '0;
    if (read_grant_valid_s) begin
      ram_read_address = read_request_address[int'(read_index_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end else begin
      ram_read_address = '0;
    end
  end

  // Record the read owner. Its data comes back from the RAM on the next cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      response_valid_r <= 1'b0;
      response_index_r <= '0;
    end else if (read_grant_valid_s) begin
      response_valid_r <= 1'b1;
      response_index_r <= read_index_s;
    end else begin
      response_valid_r <= 1'b0;
      response_index_r <= response_index_r;
    end
  end

  // Decode the pending owner into the one-hot response strobe.
  always_comb begin
    read_response_valid = '0;
    read_response_data  = ram_read_data;
    if (response_valid_r) begin
      read_response_valid[response_index_r] = 1'b1;
    end else begin
      read_response_valid = '0;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed bench for dual_port_ram_arbiter with a read-before-write RAM model
// attached to the RAM ports.
module tb_dual_port_ram_arbiter;

  logic        clock;
  logic        resetn;
  logic [3:0]  write_request_valid;
  logic [15:0] write_request_address;
  logic [31:0] write_request_data;
  logic [3:0]  write_request_ready;
  logic [3:0]  read_request_valid;
  logic [15:0] read_request_address;
  logic [3:0]  read_request_ready;
  logic [3:0]  read_response_valid;
  logic [7:0]  read_response_data;
  logic        ram_write_enable;
  logic [3:0]  ram_write_address;
  logic [7:0]  ram_write_data;
  logic        ram_read_enable;
  logic [3:0]  ram_read_address;
  logic [7:0]  ram_read_data;

  logic [7:0]  ram_memory [16];
  int          compared_count;
  int          mismatch_count;

  dual_port_ram_arbiter dut (
    .clock                 (clock),
    .resetn                (resetn),
    .write_request_valid   (write_request_valid),
    .write_request_address (write_request_address),
    .write_request_data    (write_request_data),
    .write_request_ready   (write_request_ready),
    .read_request_valid    (read_request_valid),
    .read_request_address  (read_request_address),
    .read_request_ready    (read_request_ready),
    .read_response_valid   (read_response_valid),
    .read_response_data    (read_response_data),
    .ram_write_enable      (ram_write_enable),
    .ram_write_address     (ram_write_address),
    .ram_write_data        (ram_write_data),
    .ram_read_enable       (ram_read_enable),
    .ram_read_address      (ram_read_address),
    .ram_read_data         (ram_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read-before-write RAM: a read and a write to the same address in one cycle return the old data.
  always @(posedge clock) begin
    if (ram_read_enable) ram_read_data <= ram_memory[ram_read_address];
    if (ram_write_enable) ram_memory[ram_write_address] <= ram_write_data;
  end

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_requests();
    write_request_valid   = 4'b0000;
    write_request_address = 16'h0000;
    write_request_data    = 32'h0000_0000;
    read_request_valid    = 4'b0000;
    read_request_address  = 16'h0000;
  endtask

  task automatic set_write(input int client, input logic [3:0] address, input logic [7:0] data);
    write_request_valid[client]            = 1'b1;
    write_request_address[client*4 +: 4]   = address;
    write_request_data[client*8 +: 8]      = data;
  endtask

  task automatic set_read(input int client, input logic [3:0] address);
    read_request_valid[client]           = 1'b1;
    read_request_address[client*4 +: 4]  = address;
  endtask

  logic [3:0] rr_order [8];
  logic [3:0] b2b_order [6];

  initial begin
    compared_count = 0;
    mismatch_count = 0;
    rr_order  = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    b2b_order = '{4'd0, 4'd2, 4'd0, 4'd2, 4'd0, 4'd2};
    resetn = 1'b0;
    clear_requests();

    // Reset with every client requesting on both ports.
    for (int i = 0; i < 4; i++) begin
      set_write(i, 4'(i), 8'(i));
      set_read(i, 4'(i));
    end
    step();
    step();
    settle();
    check_value("reset_write_ready", 32'(write_request_ready), 32'h0);
    check_value("reset_read_ready", 32'(read_request_ready), 32'h0);
    check_value("reset_ram_write_enable", 32'(ram_write_enable), 32'h0);
    check_value("reset_ram_read_enable", 32'(ram_read_enable), 32'h0);
    check_value("reset_response_valid", 32'(read_response_valid), 32'h0);
    resetn = 1'b1;
    settle();
    check_value("release_write_ready", 32'(write_request_ready), 32'h1);
    check_value("release_read_ready", 32'(read_request_ready), 32'h1);
    step();
    clear_requests();
    settle();
    check_value("release_response_valid", 32'(read_response_valid), 32'h1);

    // Write then read: both pointers are now 1.
    set_write(1, 4'd3, 8'hA5);
    settle();
    check_value("wr_ready", 32'(write_request_ready), 32'h2);
    check_value("wr_address", 32'(ram_write_address), 32'h3);
    check_value("wr_data", 32'(ram_write_data), 32'hA5);
    step();
    clear_requests();
    set_read(2, 4'd3);
    settle();
    check_value("rd_ready", 32'(read_request_ready), 32'h4);
    check_value("rd_address", 32'(ram_read_address), 32'h3);
    step();
    clear_requests();
    settle();
    check_value("rd_response_valid", 32'(read_response_valid), 32'h4);
    check_value("rd_response_data", 32'(read_response_data), 32'hA5);

    // Round-robin write: the write pointer starts at 2.
    for (int i = 0; i < 4; i++) set_write(i, 4'(8 + i), 8'(8'h30 + i));
    for (int k = 0; k < 8; k++) begin
      settle();
      check_value($sformatf("rr_ready_%0d", k), 32'(write_request_ready), 32'(4'b0001 << rr_order[k]));
      check_value($sformatf("rr_address_%0d", k), 32'(ram_write_address), 32'(rr_order[k] + 4'd8));
      step();
    end
    clear_requests();

    // Same-address collision: the read returns the data held before the write.
    set_write(2, 4'd5, 8'h11);
    settle();
    check_value("col_setup_ready", 32'(write_request_ready), 32'h4);
    step();
    clear_requests();
    set_write(0, 4'd5, 8'h22);
    set_read(3, 4'd5);
    settle();
    check_value("col_write_ready", 32'(write_request_ready), 32'h1);
    check_value("col_read_ready", 32'(read_request_ready), 32'h8);
    step();
    write_request_valid = 4'b0000;
    settle();
    check_value("col_old_valid", 32'(read_response_valid), 32'h8);
    check_value("col_old_data", 32'(read_response_data), 32'h11);
    check_value("col_reread_ready", 32'(read_request_ready), 32'h8);
    step();
    clear_requests();
    settle();
    check_value("col_new_valid", 32'(read_response_valid), 32'h8);
    check_value("col_new_data", 32'(read_response_data), 32'h22);

    // Back-to-back reads by clients 0 and 2 from addresses 1 and 2.
    set_write(1, 4'd1, 8'h10);
    settle();
    step();
    clear_requests();
    set_write(2, 4'd2, 8'h20);
    settle();
    step();
    clear_requests();
    set_read(0, 4'd1);
    set_read(2, 4'd2);
    for (int k = 0; k < 6; k++) begin
      settle();
      if (k > 0) begin
        check_value($sformatf("b2b_valid_%0d", k - 1), 32'(read_response_valid), 32'(4'b0001 << b2b_order[k-1]));
        check_value($sformatf("b2b_data_%0d", k - 1), 32'(read_response_data),
                    (b2b_order[k-1] == 4'd0) ? 32'h10 : 32'h20);
      end
      check_value($sformatf("b2b_ready_%0d", k), 32'(read_request_ready), 32'(4'b0001 << b2b_order[k]));
      step();
    end
    clear_requests();
    settle();
    check_value("b2b_valid_5", 32'(read_response_valid), 32'h4);
    check_value("b2b_data_5", 32'(read_response_data), 32'h20);

    // Reset mid-read: the read pointer is 3 and the write pointer is 3.
    set_read(1, 4'd1);
    settle();
    check_value("mid_read_ready", 32'(read_request_ready), 32'h2);
    resetn = 1'b0;
    step();
    settle();
    check_value("mid_response_dropped", 32'(read_response_valid), 32'h0);
    check_value("mid_reset_read_ready", 32'(read_request_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_write(i, 4'(12 + i), 8'(8'h40 + i));
      set_read(i, 4'(i));
    end
    step();
    resetn = 1'b1;
    settle();
    check_value("post_reset_write_ready", 32'(write_request_ready), 32'h1);
    check_value("post_reset_read_ready", 32'(read_request_ready), 32'h1);
    step();
    clear_requests();
    settle();
    check_value("post_reset_response", 32'(read_response_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
    $finish;
  end

endmodule
